// File: rtl/tb_irq_aggregator_if.sv
// ---------------------------------------------------------------------------
// tb_irq_aggregator_if
// Purpose : carries the interrupt-ID offer handshake between the aggregator
//           (master) and its consumer (slave).
// Signals : o_valid  - an interrupt ID is being offered (master -> slave)
//           o_id     - index of the offered source     (master -> slave)
//           i_ready  - consumer accepts the offered ID  (slave -> master)
// ---------------------------------------------------------------------------
interface tb_irq_aggregator_if #(
  parameter int ID_WIDTH = 3
);
  logic                o_valid;
  logic                i_ready;
  logic [ID_WIDTH-1:0] o_id;

  modport master (
    output o_valid,
    output o_id,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_id,
    output i_ready
  );
endinterface

// File: rtl/tb_irq_aggregator.sv
// ---------------------------------------------------------------------------
// tb_irq_aggregator
// Purpose : synchronizes WIDTH asynchronous interrupt lines, records them as
//           pending (edge or level triggered per source), tracks lost edge
//           events as sticky overflow, and offers the lowest-index enabled
//           pending source through a valid/ready handshake.
// Ports   : i_clk        - clock, all state on its rising edge
//           i_rst        - asynchronous active-high reset
//           i_irq        - raw interrupt lines (asynchronous)
//           i_edge_mode  - per source 1 = rising edge, 0 = level
//           i_mask       - per source enable for arbitration and summary
//           i_clear      - per source one-cycle clear of pending/overflow
//           o_irq        - OR of enabled pending sources (combinational)
//           o_pending    - pending register
//           o_overflow   - sticky lost-event flags
//           irq_if       - master side of the ID offer handshake
// ---------------------------------------------------------------------------
module tb_irq_aggregator #(
  parameter int WIDTH    = 8,
  parameter int ID_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_irq,
  input  logic [WIDTH-1:0]     i_edge_mode,
  input  logic [WIDTH-1:0]     i_mask,
  input  logic [WIDTH-1:0]     i_clear,
  output logic                 o_irq,
  output logic [WIDTH-1:0]     o_pending,
  output logic [WIDTH-1:0]     o_overflow,
  tb_irq_aggregator_if.master  irq_if
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  // Lowest set index of a vector; 0 when the vector is empty.
  function automatic logic [ID_WIDTH-1:0] f_lowest(input logic [WIDTH-1:0] v);
    logic [ID_WIDTH-1:0] idx;
    idx = {ID_WIDTH{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ID_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [WIDTH-1:0]    r_sync1;
  logic [WIDTH-1:0]    r_sync;
  logic [WIDTH-1:0]    r_sync_q;
  logic [WIDTH-1:0]    r_pending;
  logic [WIDTH-1:0]    r_overflow;
  state_t              r_state;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  logic [WIDTH-1:0]    w_rise;
  logic [WIDTH-1:0]    w_set;
  logic [WIDTH-1:0]    w_eligible;
  logic [WIDTH-1:0]    w_hs_clr;
  logic [WIDTH-1:0]    w_pending_nxt;
  logic [WIDTH-1:0]    w_overflow_nxt;
  logic                w_handshake;
  state_t              w_state_nxt;
  logic [ID_WIDTH-1:0] w_id_nxt;

  assign w_rise      = r_sync & ~r_sync_q;
  // Edge sources set on a synchronized rising edge, level sources whenever high.
  assign w_set       = (i_edge_mode & w_rise) | (~i_edge_mode & r_sync);
  assign w_eligible  = r_pending & i_mask;
  assign w_handshake = r_valid & irq_if.i_ready;

  // Two-flop synchronizer plus one-cycle delayed copy for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= {WIDTH{1'b0}};
      r_sync   <= {WIDTH{1'b0}};
      r_sync_q <= {WIDTH{1'b0}};
    end else begin
      r_sync1  <= i_irq;
      r_sync   <= r_sync1;
      r_sync_q <= r_sync;
    end
  end

  // Decode which pending bit the current handshake retires.
  always_comb begin
    w_hs_clr = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (w_handshake && (r_id == ID_WIDTH'(i))) begin
        w_hs_clr[i] = 1'b1;
      end else begin
        w_hs_clr[i] = 1'b0;
      end
    end
  end

  // Pending/overflow next state: clear beats set, set beats handshake retire.
  always_comb begin
    w_pending_nxt  = r_pending;
    w_overflow_nxt = r_overflow;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_clear[i]) begin
        w_pending_nxt[i]  = 1'b0;
        w_overflow_nxt[i] = 1'b0;
      end else if (w_set[i]) begin
        w_pending_nxt[i] = 1'b1;
        // A second edge is only lost if the first is not being retired now.
        if (i_edge_mode[i] && r_pending[i] && !w_hs_clr[i]) begin
          w_overflow_nxt[i] = 1'b1;
        end else begin
          w_overflow_nxt[i] = r_overflow[i];
        end
      end else if (w_hs_clr[i]) begin
        w_pending_nxt[i]  = 1'b0;
        w_overflow_nxt[i] = r_overflow[i];
      end else begin
        w_pending_nxt[i]  = r_pending[i];
        w_overflow_nxt[i] = r_overflow[i];
      end
    end
  end

  // Pending and overflow registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= {WIDTH{1'b0}};
      r_overflow <= {WIDTH{1'b0}};
    end else begin
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Arbiter next state; the offered ID is latched only on entry to OFFER.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt = S_OFFER;
          w_id_nxt    = f_lowest(w_eligible);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OFFER: begin
        // Offer is never withdrawn; only the handshake ends it, which also
        // forces the one-cycle bubble through IDLE.
        if (irq_if.i_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OFFER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Arbiter state, registered valid and registered ID.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= {ID_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_OFFER);
      r_id    <= w_id_nxt;
    end
  end

  assign o_irq          = |w_eligible;
  assign o_pending      = r_pending;
  assign o_overflow     = r_overflow;
  assign irq_if.o_valid = r_valid;
  assign irq_if.o_id    = r_id;

endmodule

// File: tb/tb_tb_irq_aggregator.sv
// ---------------------------------------------------------------------------
// tb_tb_irq_aggregator
// Purpose : directed self-checking bench for tb_irq_aggregator (WIDTH = 8).
//           Inputs change 1 time unit after a rising edge, outputs are
//           sampled at the same point.
// ---------------------------------------------------------------------------
module tb_tb_irq_aggregator;

  localparam int WIDTH    = 8;
  localparam int ID_WIDTH = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] irq;
  logic [WIDTH-1:0] edge_mode;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clear;
  logic             sum_irq;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] overflow;

  int n_cmp;
  int n_fail;
  int offers;

  tb_irq_aggregator_if #(.ID_WIDTH(ID_WIDTH)) u_if ();

  tb_irq_aggregator #(.WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_irq       (irq),
    .i_edge_mode (edge_mode),
    .i_mask      (mask),
    .i_clear     (clear),
    .o_irq       (sum_irq),
    .o_pending   (pending),
    .o_overflow  (overflow),
    .irq_if      (u_if)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    offers     = 0;
    rst        = 1'b1;
    irq        = 8'h00;
    edge_mode  = 8'hFE;   // bit 0 level, all others edge
    mask       = 8'hFF;
    clear      = 8'h00;
    u_if.i_ready = 1'b1;

    // Reset state
    step(2);
    check("rst_valid",    64'(u_if.o_valid), 64'd0);
    check("rst_id",       64'(u_if.o_id),    64'd0);
    check("rst_pending",  64'(pending),      64'h00);
    check("rst_overflow", 64'(overflow),     64'h00);
    check("rst_irq",      64'(sum_irq),      64'd0);
    rst = 1'b0;
    step(1);

    // Single edge on bit 3: pending after N+2, offer after N+3, retired at N+4
    irq = 8'h08;
    step(1);                       // edge N
    irq = 8'h00;
    step(1);                       // N+1
    check("b3_pend_n1",  64'(pending), 64'h00);
    step(1);                       // N+2
    check("b3_pend_n2",  64'(pending), 64'h08);
    check("b3_valid_n2", 64'(u_if.o_valid), 64'd0);
    check("b3_sumirq",   64'(sum_irq), 64'd1);
    step(1);                       // N+3
    check("b3_valid_n3", 64'(u_if.o_valid), 64'd1);
    check("b3_id_n3",    64'(u_if.o_id), 64'd3);
    step(1);                       // N+4
    check("b3_valid_n4", 64'(u_if.o_valid), 64'd0);
    check("b3_pend_n4",  64'(pending), 64'h00);
    step(3);
    check("b3_no_reoffer", 64'(u_if.o_valid), 64'd0);

    // Bits 5 and 2 together: 2, one idle cycle, then 5
    irq = 8'h24;
    step(1);
    irq = 8'h00;
    step(2);
    check("b25_pend",    64'(pending), 64'h24);
    step(1);
    check("b25_valid1",  64'(u_if.o_valid), 64'd1);
    check("b25_id1",     64'(u_if.o_id), 64'd2);
    step(1);
    check("b25_bubble",  64'(u_if.o_valid), 64'd0);
    check("b25_pend2",   64'(pending), 64'h20);
    step(1);
    check("b25_valid2",  64'(u_if.o_valid), 64'd1);
    check("b25_id2",     64'(u_if.o_id), 64'd5);
    step(1);
    check("b25_done",    64'(u_if.o_valid), 64'd0);
    check("b25_pend3",   64'(pending), 64'h00);

    // Bit 1 twice with consumer stalled: overflow, stable offer, clear
    u_if.i_ready = 1'b0;
    irq = 8'h02;
    step(1);
    irq = 8'h00;
    step(1);
    irq = 8'h02;
    step(1);
    irq = 8'h00;
    step(3);
    check("b1_overflow", 64'(overflow), 64'h02);
    for (int k = 0; k < 10; k++) begin
      check("b1_stall_valid", 64'(u_if.o_valid), 64'd1);
      check("b1_stall_id",    64'(u_if.o_id), 64'd1);
      step(1);
    end
    clear = 8'h02;
    step(1);
    clear = 8'h00;
    check("b1_clr_overflow", 64'(overflow), 64'h00);
    check("b1_clr_pending",  64'(pending), 64'h00);
    check("b1_offer_kept",   64'(u_if.o_valid), 64'd1);
    u_if.i_ready = 1'b1;
    step(1);
    check("b1_hs_valid",     64'(u_if.o_valid), 64'd0);
    check("b1_hs_pending",   64'(pending), 64'h00);

    // Bit 0 level held high: offer every second cycle
    step(2);
    irq = 8'h01;
    step(3);                       // pending set, first offer next edge
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("b0_lvl_valid", 64'(u_if.o_valid), ((k % 2) == 0) ? 64'd1 : 64'd0);
      check("b0_lvl_id",    64'(u_if.o_id), 64'd0);
    end
    irq = 8'h00;
    offers = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (u_if.o_valid === 1'b1) begin
        offers++;
      end else begin
        offers = offers;
      end
    end
    check("b0_tail_max3", 64'(offers <= 3), 64'd1);
    check("b0_tail_min1", 64'(offers >= 1), 64'd1);
    check("b0_tail_pend", 64'(pending), 64'h00);

    // Bit 4 masked while pending: no summary, no offer until unmasked
    mask = 8'hEF;
    irq  = 8'h10;
    step(1);
    irq  = 8'h00;
    step(2);
    check("b4_pend",        64'(pending), 64'h10);
    check("b4_masked_irq",  64'(sum_irq), 64'd0);
    step(2);
    check("b4_masked_vld",  64'(u_if.o_valid), 64'd0);
    u_if.i_ready = 1'b0;
    mask = 8'hFF;
    #1;
    check("b4_unmask_irq",  64'(sum_irq), 64'd1);
    step(1);
    check("b4_offer_vld",   64'(u_if.o_valid), 64'd1);
    check("b4_offer_id",    64'(u_if.o_id), 64'd4);
    irq = 8'h40;
    step(1);
    irq = 8'h00;
    step(2);
    check("b46_pend",       64'(pending), 64'h50);

    // Reset mid-offer takes effect without a clock edge
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid",  64'(u_if.o_valid), 64'd0);
    check("rst_mid_pend",   64'(pending), 64'h00);
    check("rst_mid_sumirq", 64'(sum_irq), 64'd0);
    check("rst_mid_id",     64'(u_if.o_id), 64'd0);

    // Line already high at reset release counts as a rising edge
    irq = 8'h80;
    step(1);
    rst = 1'b0;
    u_if.i_ready = 1'b1;
    step(3);
    check("b7_rel_pend",    64'(pending), 64'h80);
    check("b7_rel_valid0",  64'(u_if.o_valid), 64'd0);
    step(1);
    check("b7_rel_valid",   64'(u_if.o_valid), 64'd1);
    check("b7_rel_id",      64'(u_if.o_id), 64'd7);
    step(1);
    check("b7_rel_done",    64'(u_if.o_valid), 64'd0);
    check("b7_rel_pend2",   64'(pending), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_irq_aggregator.md
TB_IRQ_AGGREGATOR -- requirements
Module: tb_irq_aggregator

Interface
REQ-001 Parameter WIDTH, default 8: number of interrupt sources, legal range 1..64.
REQ-002 Parameter ID_WIDTH, default (WIDTH > 1) ? $clog2(WIDTH) : 1: width of the source index.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_irq  input  WIDTH  raw interrupt lines, asynchronous to i_clk.
REQ-007 i_edge_mode  input  WIDTH  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
REQ-008 i_mask  input  WIDTH  per source enable: 1 = eligible for arbitration and summary.
REQ-009 i_clear  input  WIDTH  one-cycle pulse per bit: clears that source's pending and overflow.
REQ-010 o_irq  output  1  summary: OR of (pending AND i_mask).
REQ-011 o_valid  output  1  an interrupt ID is offered.
REQ-012 i_ready  input  1  consumer accepts the offered ID.
REQ-013 o_id  output  ID_WIDTH  index of the offered source.
REQ-014 o_pending  output  WIDTH  pending register.
REQ-015 o_overflow  output  WIDTH  sticky lost-event flags.

Function
REQ-016 Each i_irq bit passes through a 2-flop synchronizer; the second stage is "sync".
- Rising edge = sync & ~sync_q, where sync_q is sync delayed by one cycle.
REQ-017 Edge mode: a rising edge sets pending; level mode: sync = 1 sets pending every cycle.
- An i_irq bit rising before clock edge N gives pending = 1 after edge N+2 and o_valid = 1 after edge N+3.
REQ-018 Edge mode: a rising edge while pending is already 1 and not cleared in the same cycle sets overflow (sticky).
- Level mode never sets overflow.
REQ-019 Arbiter FSM has two states, IDLE and OFFER:
- IDLE -> OFFER when any (pending & i_mask) bit is set.
- On that transition, the lowest set index is latched into o_id.
REQ-020 In OFFER, o_valid = 1 and o_id holds stable until the cycle in which o_valid & i_ready is true.
- Changes to mask, clear or pending do not withdraw the offer.
REQ-021 On handshake, pending[o_id] clears and the FSM returns to IDLE.
- A one-cycle bubble is mandatory: o_valid = 0 for at least one cycle between offers.
REQ-022 A set event and a handshake-clear of the same bit in the same cycle leave pending = 1 and do not set overflow.
REQ-023 i_clear takes priority over set events in the same cycle: pending and overflow become 0.
- If the cleared bit is the one being offered, the offer still completes.
- The later handshake on a bit already at 0 is harmless.
REQ-024 A level source still high after its handshake re-pends on the next cycle.
REQ-025 o_irq is combinational from the pending register and i_mask.
- o_pending, o_overflow, o_valid and o_id are driven directly from registers.
REQ-026 With WIDTH = 1, o_id is constant 0.

Reset
REQ-027 When i_rst is asserted, all synchronizer flops, sync_q, pending and overflow clear to 0, the FSM goes to IDLE, and o_valid, o_id and o_irq are 0.
REQ-028 After reset release, an i_irq line already high is seen as a rising edge in edge mode (sync_q = 0).
REQ-029 Asserting reset during OFFER drops o_valid immediately, without waiting for a handshake.

Verification
REQ-030 WIDTH = 8, bit 3 edge mode and unmasked, i_ready = 1: pulse i_irq[3] at edge N.
- o_valid = 1 and o_id = 3 after edge N+3.
- Pending[3] = 0 after the handshake; no second offer.
REQ-031 Raise bits 5 and 2 simultaneously (edge mode):
- Offers are o_id = 2, then o_id = 5, with exactly one idle cycle between them.
REQ-032 Bit 1 edge mode, i_ready = 0: pulse i_irq[1] twice.
- o_overflow[1] = 1 and o_id stays 1, with o_valid held across 10 stall cycles.
- A subsequent i_clear[1] zeroes o_overflow[1].
REQ-033 Bit 0 level mode, held high, i_ready = 1:
- Repeated offers of ID 0 every 2 cycles.
- After i_irq[0] falls, at most 3 further offers appear.
REQ-034 Mask bit 4 while it is pending: o_irq = 0 and no offer; unmasking produces the offer.
- Asserting i_rst mid-OFFER forces o_valid = 0 and all pending to 0 without waiting for an edge.
